// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel enable, syncs, blanking and line/frame markers.
// Optional 16-bit frame_count output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int CNT_W    = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  output logic             pix_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             hvideo_on,
  output logic             vvideo_on,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  , output logic [15:0]    frame_count
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) || longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_size_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W");
  end
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic HS_A = HS_POL != 0;
  localparam logic VS_A = VS_POL != 0;
  logic [DIV_W-1:0] div, div_nxt;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic h_wrap, v_wrap, ls_nxt, fs_nxt;
  // pix_tick mirrors div == DIV_LAST, so counters step in the clk after the tick is visible
  always_comb begin
    h_wrap  = pix_tick && pixel_x == H_LAST;
    v_wrap  = h_wrap && pixel_y == V_LAST;
    div_nxt = restart || div == DIV_LAST ? '0 : div + 1'b1;
    x_nxt   = restart || h_wrap ? '0 : pix_tick ? pixel_x + 1'b1 : pixel_x;
    y_nxt   = restart || v_wrap ? '0 : h_wrap ? pixel_y + 1'b1 : pixel_y;
    ls_nxt  = restart || h_wrap;
    fs_nxt  = restart || v_wrap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      pix_tick    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= !HS_A;
      vsync       <= !VS_A;
      hvideo_on   <= 1'b1;
      vvideo_on   <= 1'b1;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      pix_tick    <= div_nxt == DIV_LAST;
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      hsync       <= x_nxt >= HS_B && x_nxt <= HS_E ? HS_A : !HS_A;
      vsync       <= y_nxt >= VS_B && y_nxt <= VS_E ? VS_A : !VS_A;
      hvideo_on   <= x_nxt < H_ACT;
      vvideo_on   <= y_nxt < V_ACT;
      video_on    <= x_nxt < H_ACT && y_nxt < V_ACT;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_count <= '0;
    else if (fs_nxt) frame_count <= frame_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a small raster (23x10, divide-by-3) against a closed-form tick model.
module tb_vga_timing_gen;
  localparam int D = 3, W = 5;
  localparam int HA = 16, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int HP = 0, VP = 1;
  logic clk = 0, rst = 1, restart = 0;
  logic pix_tick, hsync, vsync, hvideo_on, vvideo_on, video_on, line_start, frame_start;
  logic [W-1:0] pixel_x, pixel_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count;
  int fce = 0;
`endif
  int checks = 0, failures = 0;
  int k = 0, mx = 0, my = 0;
  logic rf = 0;
  vga_timing_gen #(
    .CLK_DIV(D), .CNT_W(W),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .pix_tick(pix_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
    .hvideo_on(hvideo_on), .vvideo_on(vvideo_on), .video_on(video_on),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );
  always #5 clk = ~clk;
  wire [17:0] obs = {pix_tick, pixel_x, pixel_y, hsync, vsync, hvideo_on, vvideo_on, video_on, line_start, frame_start};
  // k counts clks since reset release or the last restart edge; tick count is k/D
  task automatic step();
    logic [17:0] e;
    logic pt, ls, fs, hs, vs;
    int t;
    @(posedge clk);
    if (restart) begin k = 0; rf = 1; end else k++;
    t  = k / D;
    mx = t % HT;
    my = (t / HT) % VT;
    pt = (k % D) == D - 1;
    ls = k == 0 ? rf : (k % D == 0 && mx == 0);
    fs = k == 0 ? rf : (k % D == 0 && mx == 0 && my == 0);
    hs = (mx >= HA + HF && mx <= HA + HF + HS - 1) ? 1'(HP) : !1'(HP);
    vs = (my >= VA + VF && my <= VA + VF + VS - 1) ? 1'(VP) : !1'(VP);
    e  = {pt, W'(mx), W'(my), hs, vs, mx < HA, my < VA, mx < HA && my < VA, ls, fs};
    #1;
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL raster k=%0d got=%h exp=%h", k, obs, e);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (fs) fce++;
    checks++;
    assert (frame_count === 16'(fce)) else begin
      failures++;
      $error("FAIL frame_count got=%0d exp=%0d", frame_count, fce);
    end
`endif
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  localparam logic [17:0] RST_V = {1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 32'(obs), 32'(RST_V));
    #3 rst = 0; k = 0; rf = 0;
    repeat (3) step();
    chk("first_tick_x1", 32'(pixel_x), 32'd1);
    for (int i = 0; i < 2 * HT * VT * D + 20; i++) step();
    for (int i = 0; i < 2000 && !(k % D == D - 1 && mx == 5 && my == 3); i++) step();
    chk("reach_restart_point", 32'(pix_tick && mx == 5 && my == 3), 32'd1);
    restart = 1;
    step();
    restart = 0;
    chk("restart_xy", 32'({pixel_x, pixel_y, line_start, frame_start}), 32'({5'd0, 5'd0, 2'b11}));
    for (int i = 0; i < 120; i++) step();
    restart = 1;
    repeat (3) step();
    chk("restart_held", 32'({pixel_x, pixel_y, line_start, frame_start}), 32'({5'd0, 5'd0, 2'b11}));
    restart = 0;
    for (int i = 0; i < 300; i++) step();
    for (int i = 0; i < 2000 && mx != HA + HF + 1; i++) step();
    chk("hsync_asserted_pre_rst", 32'(hsync), 32'(HP));
    #3 rst = 1;
    #1 chk("async_reset_midline", 32'(obs), 32'(RST_V));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_count_reset", 32'(frame_count), 32'd0);
    fce = 0;
`endif
    @(posedge clk);
    #1 chk("reset_held", 32'(obs), 32'(RST_V));
    #3 rst = 0; k = 0; rf = 0;
    repeat (3) step();
    chk("post_rst_first_tick", 32'(pixel_x), 32'd1);
    for (int i = 0; i < HT * VT * D + 10; i++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
